div_reconstruct: RTL and testbench

// Sequential shift-add multiplier-accumulator: the inverse of the 16/8 restoring

---
 rtl/div_reconstruct.sv | 155 +++++++++++++++
 tb/tb_div_reconstruct.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_reconstruct.sv
// Sequential shift-add multiply-accumulate that rebuilds Dividend = Quotient*Divisor + Remainder,
// the inverse of the restoring divider. Rejects operand sets a divider could not have produced.
module div_reconstruct #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   Divisor,
    input  logic [W-1:0]   Quotient,
    input  logic [W-1:0]   Remainder,
    output logic [2*W-1:0] Dividend,
    output logic           busy,
    output logic           done,
    output logic           error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MULT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [W-1:0]     d_r;
    logic [W-1:0]     q_r;
    logic [W-1:0]     r_r;
    logic [2*W-1:0]   acc_r;
    logic [2*W-1:0]   mcand_r;
    logic [W-1:0]     mplier_r;
    logic [CW-1:0]    cnt_r;
    logic [2*W-1:0]   dividend_r;
    logic             busy_r;
    logic             done_r;
    logic             error_r;
    logic             operand_bad_s;
    logic             last_iter_s;
    logic [2*W-1:0]   acc_step_s;

    // Operand validity, final-iteration detect and the accumulate step of the current iteration
    always_comb begin
        operand_bad_s = (d_r == {W{1'b0}}) || (r_r >= d_r);
        last_iter_s   = (cnt_r == CW'(W - 1));
        if (mplier_r[0]) begin
            acc_step_s = acc_r + mcand_r;
        end else begin
            acc_step_s = acc_r;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = CHECK;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CHECK: begin
                if (operand_bad_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = MULT;
                end
            end
            MULT: begin
                if (last_iter_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = MULT;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register and datapath; Dividend is written on the edge into DONE so it is valid with done
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            d_r        <= {W{1'b0}};
            q_r        <= {W{1'b0}};
            r_r        <= {W{1'b0}};
            acc_r      <= {(2*W){1'b0}};
            mcand_r    <= {(2*W){1'b0}};
            mplier_r   <= {W{1'b0}};
            cnt_r      <= {CW{1'b0}};
            dividend_r <= {(2*W){1'b0}};
            error_r    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        d_r        <= Divisor;
                        q_r        <= Quotient;
                        r_r        <= Remainder;
                        dividend_r <= {(2*W){1'b0}};
                        error_r    <= 1'b0;
                    end
                end
                CHECK: begin
                    if (operand_bad_s) begin
                        error_r    <= 1'b1;
                        dividend_r <= {(2*W){1'b0}};
                    end else begin
                        acc_r    <= {{W{1'b0}}, r_r};
                        mcand_r  <= {{W{1'b0}}, d_r};
                        mplier_r <= q_r;
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                MULT: begin
                    acc_r    <= acc_step_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_iter_s) begin
                        dividend_r <= acc_step_s;
                    end
                end
                DONE: begin
                    cnt_r <= {CW{1'b0}};
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Status flags registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == CHECK) || (state_nx_s == MULT);
            done_r <= (state_nx_s == DONE);
        end
    end

    assign Dividend = dividend_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign error    = error_r;

endmodule

// File: tb/tb_div_reconstruct.sv
// Self-checking bench for div_reconstruct: directed scenarios plus random round trips
// checked against plain arithmetic (Q*D+R, error when D==0 or R>=D).
module tb_div_reconstruct;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  Divisor;
    logic [7:0]  Quotient;
    logic [7:0]  Remainder;
    logic [15:0] Dividend;
    logic        busy;
    logic        done;
    logic        error;

    int n_vec;
    int n_err;

    div_reconstruct #(.W(8), .CW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Dividend  (Dividend),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_err(input int d, input int r);
        return (d == 0) || (r >= d);
    endfunction

    function automatic logic [15:0] exp_div(input int d, input int q, input int r);
        if (exp_err(d, r)) return 16'd0;
        return 16'(q * d + r);
    endfunction

    function automatic int exp_lat(input int d, input int r);
        if (exp_err(d, r)) return 2;
        return 10;
    endfunction

    // Called just after a negedge; returns at the negedge of the cycle where done is seen (0 = timeout)
    task automatic run_op(input logic [7:0] d, input logic [7:0] q, input logic [7:0] r,
                          output int done_cyc, output int busy_cyc, output int div_moved);
        Divisor   = d;
        Quotient  = q;
        Remainder = r;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        done_cyc  = 0;
        busy_cyc  = 0;
        div_moved = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            if (busy) busy_cyc++;
            if (Dividend !== 16'd0) div_moved++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        Divisor = 8'd0; Quotient = 8'd0; Remainder = 8'd0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({Dividend, busy, done, error} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_state: got Dividend=%0d busy=%b done=%b error=%b, want all 0",
                     Dividend, busy, done, error);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int dc, bc, dm;
        run_op(8'd7, 8'd35, 8'd3, dc, bc, dm);
        n_vec++;
        if (dc !== 10) begin n_err++; $display("FAIL basic_latency: done at cycle %0d, want 10", dc); end
        n_vec++;
        if (bc !== 9) begin n_err++; $display("FAIL basic_busy: busy for %0d cycles, want 9", bc); end
        n_vec++;
        if (dm !== 0) begin n_err++; $display("FAIL basic_stable: Dividend nonzero in %0d busy cycles, want 0", dm); end
        n_vec++;
        if (Dividend !== 16'd248 || error !== 1'b0) begin
            n_err++; $display("FAIL basic_result: got %0d err=%b, want 248 err=0", Dividend, error);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || Dividend !== 16'd248) begin
            n_err++; $display("FAIL basic_pulse: done=%b Dividend=%0d after done, want 0 and 248", done, Dividend);
        end
    endtask

    task automatic test_error();
        int dc, bc, dm;
        run_op(8'd0, 8'd5, 8'd0, dc, bc, dm);
        n_vec++;
        if (dc !== 2) begin n_err++; $display("FAIL err_latency: done at cycle %0d, want 2", dc); end
        n_vec++;
        if (error !== 1'b1 || Dividend !== 16'd0) begin
            n_err++; $display("FAIL err_result: got err=%b Dividend=%0d, want 1 and 0", error, Dividend);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (error !== 1'b1) begin n_err++; $display("FAIL err_hold: error=%b, want 1", error); end
    endtask

    task automatic test_range();
        int dc, bc, dm;
        run_op(8'd9, 8'd4, 8'd9, dc, bc, dm);
        n_vec++;
        if (dc !== 2 || error !== 1'b1 || Dividend !== 16'd0) begin
            n_err++; $display("FAIL r_ge_d: cyc=%0d err=%b Dividend=%0d, want 2 1 0", dc, error, Dividend);
        end
        @(negedge clk);
        run_op(8'd9, 8'd4, 8'd8, dc, bc, dm);
        n_vec++;
        if (dc !== 10 || error !== 1'b0 || Dividend !== 16'd44) begin
            n_err++; $display("FAIL r_lt_d: cyc=%0d err=%b Dividend=%0d, want 10 0 44", dc, error, Dividend);
        end
        @(negedge clk);
    endtask

    task automatic test_max();
        int dc, bc, dm;
        run_op(8'd255, 8'd255, 8'd254, dc, bc, dm);
        n_vec++;
        if (dc !== 10 || Dividend !== 16'd65279 || error !== 1'b0) begin
            n_err++; $display("FAIL max: cyc=%0d Dividend=%0d err=%b, want 10 65279 0", dc, Dividend, error);
        end
        @(negedge clk);
        run_op(8'd1, 8'd0, 8'd0, dc, bc, dm);
        n_vec++;
        if (dc !== 10 || Dividend !== 16'd0 || error !== 1'b0) begin
            n_err++; $display("FAIL zero_q: cyc=%0d Dividend=%0d err=%b, want 10 0 0", dc, Dividend, error);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int dc;
        Divisor = 8'd7; Quotient = 8'd35; Remainder = 8'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        Divisor = 8'd200; Quotient = 8'd100; Remainder = 8'd50;
        dc = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                dc = c;
                break;
            end
            start = (c == 3 || c == 9);
            @(negedge clk);
        end
        start = 1'b0;
        n_vec++;
        if (dc !== 10 || Dividend !== 16'd248 || error !== 1'b0) begin
            n_err++; $display("FAIL ignore_start: cyc=%0d Dividend=%0d err=%b, want 10 248 0", dc, Dividend, error);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL ignore_restart: busy=%b done=%b after run, want 0 0", busy, done);
        end
    endtask

    task automatic test_abort();
        int dc, bc, dm, seen;
        Divisor = 8'd7; Quotient = 8'd35; Remainder = 8'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if ({Dividend, busy, done, error} !== 19'd0) begin
            n_err++;
            $display("FAIL abort_state: Dividend=%0d busy=%b done=%b error=%b, want all 0",
                     Dividend, busy, done, error);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        n_vec++;
        if (seen !== 0) begin n_err++; $display("FAIL abort_quiet: %0d active cycles after abort, want 0", seen); end
        run_op(8'd13, 8'd76, 8'd12, dc, bc, dm);
        n_vec++;
        if (dc !== 10 || Dividend !== 16'd1000) begin
            n_err++; $display("FAIL abort_next: cyc=%0d Dividend=%0d, want 10 1000", dc, Dividend);
        end
        @(negedge clk);
    endtask

    task automatic test_round_trip();
        int dc, bc, dm, q, r, d, bad;
        q = 1000 / 13;
        r = 1000 % 13;
        run_op(8'd13, 8'(q), 8'(r), dc, bc, dm);
        n_vec++;
        if (Dividend !== 16'd1000 || error !== 1'b0) begin
            n_err++; $display("FAIL round_trip_1000: got %0d err=%b, want 1000 0", Dividend, error);
        end
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            d = int'($urandom_range(255, 1));
            r = int'($urandom_range(d - 1, 0));
            q = int'($urandom_range(255, 0));
            run_op(8'(d), 8'(q), 8'(r), dc, bc, dm);
            n_vec++;
            if (dc !== exp_lat(d, r) || Dividend !== exp_div(d, q, r) || error !== exp_err(d, r)) begin
                n_err++;
                if (bad < 10)
                    $display("FAIL random D=%0d Q=%0d R=%0d: cyc=%0d Dividend=%0d err=%b, want cyc=%0d %0d err=%b",
                             d, q, r, dc, Dividend, error, exp_lat(d, r), exp_div(d, q, r), exp_err(d, r));
                bad++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_error();
        test_range();
        test_max();
        test_ignore_start();
        test_abort();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
